// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: state encoding and bus width.
package mollusc_mem_pkg;

  localparam int BUS_W = 32;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_IF   = 2'd1;
  localparam logic [1:0] ARB_D    = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ARB_IDLE,
    S_IF   = ARB_IF,
    S_D    = ARB_D
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, execute and memory-bus signals of the arbiter.
// slave: the arbiter's view. master: the surrounding pipeline and memory.
interface mem_port_arbiter_if import mollusc_mem_pkg::*; ();
  logic             if_req;
  logic [BUS_W-1:0] if_addr;
  logic             if_valid;
  logic [BUS_W-1:0] if_rdata;
  logic             d_req;
  logic [BUS_W-1:0] d_addr;
  logic [BUS_W-1:0] d_wdata;
  logic             d_write;
  logic             d_valid;
  logic [BUS_W-1:0] d_rdata;
  logic             stall;
  logic             mem_req;
  logic [BUS_W-1:0] mem_addr;
  logic [BUS_W-1:0] mem_wdata;
  logic             mem_write;
  logic             mem_ack;
  logic [BUS_W-1:0] mem_rdata;
  logic             bus_err;

  modport slave (
    input  if_req, if_addr, d_req, d_addr, d_wdata, d_write, mem_ack, mem_rdata,
    output if_valid, if_rdata, d_valid, d_rdata, stall,
           mem_req, mem_addr, mem_wdata, mem_write, bus_err
  );

  modport master (
    output if_req, if_addr, d_req, d_addr, d_wdata, d_write, mem_ack, mem_rdata,
    input  if_valid, if_rdata, d_valid, d_rdata, stall,
           mem_req, mem_addr, mem_wdata, mem_write, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Bus watchdog: counts busy cycles without an ack, flags expiry on the
// LIMIT-th such cycle. Cleared on every grant.
module mem_arb_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expire
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign expire = run && (cnt == W'(LIMIT - 1));

  // wait counter, frozen once expired until the next grant clears it
  always_ff @(posedge clk) begin
    if (rst || clr)          cnt <= '0;
    else if (run && !expire) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported memory bus between fetch and execute load/store.
// Data wins ties unless fetch has waited STARVE_LIMIT data grants.
// Optional bus watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter import mollusc_mem_pkg::*; #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("mem_port_arbiter: parameter out of range");
  end

  arb_state_e state;
  logic [3:0] starve_cnt;
  logic       busy, ack, pulse_gap, d_wins, wd_expire;

  assign busy      = (state != S_IDLE);
  assign ack       = busy && bus.mem_req && bus.mem_ack;
  // a requester holds req through its valid cycle, so no grant is made then
  assign pulse_gap = bus.if_valid || bus.d_valid;
  assign d_wins    = bus.d_req && !(bus.if_req && (starve_cnt == 4'(STARVE_LIMIT)));
  assign bus.stall = bus.d_req && !bus.d_valid;

`ifdef MEM_ARB_TIMEOUT_EN
  logic grant;
  assign grant = (state == S_IDLE) && !pulse_gap && (bus.if_req || bus.d_req);

  mem_arb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clr    (grant),
    .run    (busy && !ack),
    .expire (wd_expire)
  );
`else
  assign wd_expire   = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

  // arbitration FSM with registered bus and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      starve_cnt    <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_write <= 1'b0;
      bus.if_valid  <= 1'b0;
      bus.d_valid   <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      bus.bus_err   <= 1'b0;
`endif
    end else begin
      bus.if_valid <= 1'b0;
      bus.d_valid  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      bus.bus_err  <= 1'b0;
`endif
      if (!bus.if_req) starve_cnt <= '0;
      unique case (state)
        S_IDLE: if (!pulse_gap) begin
          if (d_wins) begin
            state         <= S_D;
            bus.mem_req   <= 1'b1;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_write ? bus.d_wdata : '0;
            bus.mem_write <= bus.d_write;
            if (bus.if_req && starve_cnt != 4'hF) starve_cnt <= starve_cnt + 1'b1;
          end else if (bus.if_req) begin
            state         <= S_IF;
            bus.mem_req   <= 1'b1;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= '0;
            bus.mem_write <= 1'b0;
            starve_cnt    <= '0;
          end
        end
        S_IF, S_D: if (ack || wd_expire) begin
          state       <= S_IDLE;
          bus.mem_req <= 1'b0;
          if (state == S_IF) begin
            bus.if_valid <= bus.if_req;
            bus.if_rdata <= ack ? bus.mem_rdata : '0;
          end else begin
            bus.d_valid <= bus.d_req;
            if (!ack)                bus.d_rdata <= '0;
            else if (!bus.mem_write) bus.d_rdata <= bus.mem_rdata;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          bus.bus_err <= wd_expire;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
